// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle between sync_fifo's read port, the stream reader and the
// downstream valid/ready consumer.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    // The reader drives the FIFO read strobe and the stream outputs.
    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_en,
        output m_valid,
        input  m_ready,
        output m_data
    );

    // The FIFO and the downstream stage together form the opposite side.
    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_en,
        input  m_valid,
        output m_ready,
        input  m_data
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains sync_fifo into a valid/ready stream, using a 2-entry output buffer
// to hide the FIFO's one-cycle read latency at full throughput.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fifo_stream_reader_if.master bus,
    output logic [1:0]           buf_cnt,
    output logic [CNT_WIDTH-1:0] beat_cnt
);
    logic                  inflight;
    logic                  pop;
    logic [2:0]            occupancy;
    logic [1:0]            cnt_after_pop;
    logic [1:0]            buf_cnt_next;
    logic [DATA_WIDTH-1:0] slot0;
    logic [DATA_WIDTH-1:0] slot1;
    logic [DATA_WIDTH-1:0] slot0_next;
    logic [DATA_WIDTH-1:0] slot1_next;

    assign pop       = bus.m_valid & bus.m_ready;
    assign occupancy = {1'b0, buf_cnt} + {2'b00, inflight};

    // A read is only issued when its word is guaranteed a buffer slot on arrival.
    assign bus.fifo_rd_en = rst_n & ~bus.fifo_empty & ((occupancy < 3'd2) | pop);
    assign bus.m_data     = slot0;

    always_comb begin
        cnt_after_pop = buf_cnt - {1'b0, pop};
        buf_cnt_next  = cnt_after_pop + {1'b0, inflight};
        slot0_next    = slot0;
        slot1_next    = slot1;
        if (pop && (buf_cnt == 2'd2)) begin
            slot0_next = slot1;
        end
        // The arriving word lands behind whatever survives this cycle's pop.
        if (inflight) begin
            if (cnt_after_pop == 2'd0) begin
                slot0_next = bus.fifo_data;
            end else begin
                slot1_next = bus.fifo_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight    <= 1'b0;
            buf_cnt     <= 2'd0;
            bus.m_valid <= 1'b0;
            slot0       <= '0;
            slot1       <= '0;
            beat_cnt    <= '0;
        end else begin
            inflight    <= bus.fifo_rd_en;
            buf_cnt     <= buf_cnt_next;
            bus.m_valid <= (buf_cnt_next != 2'd0);
            slot0       <= slot0_next;
            slot1       <= slot1_next;
            if (pop) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end
endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Downstream consumer stage for sync_fifo.
- Drains the FIFO through its rd_en/data_out/empty interface and presents the words on a valid/ready stream for the next pipeline stage.
- Hides the FIFO's one-cycle read latency with a 2-entry output buffer, so it sustains one word per cycle, never reads an empty FIFO, and never drops or reorders data.

Parameters:
- DATA_WIDTH, 8, word width; must match the sync_fifo DATA_WIDTH.
- CNT_WIDTH, 16, width of the delivered-beat counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fifo_empty  input  1  sync_fifo empty flag.
- fifo_data  input  DATA_WIDTH  sync_fifo data_out; valid in the cycle after fifo_rd_en is high.
- fifo_rd_en  output  1  sync_fifo rd_en; combinational.
- m_valid  output  1  stream word valid; registered.
- m_ready  input  1  downstream accept.
- m_data  output  DATA_WIDTH  stream word; registered, equals buffer head.
- buf_cnt  output  2  words held in the output buffer (0..2).
- beat_cnt  output  CNT_WIDTH  count of completed stream transfers; wraps.

Behaviour:
- Reset: asynchronous, active-low.
  - Clears buf_cnt=0, m_valid=0, m_data=0, beat_cnt=0 and the internal in-flight flag.
  - fifo_rd_en=0 while rst_n is low.
- FIFO read timing: sync_fifo registers data_out on the clk edge that samples rd_en. An in-flight flag inflight <= fifo_rd_en marks that fifo_data is valid in the current cycle.
- Pop: pop = m_valid & m_ready. The head word is removed at the clk edge.
- Issue rule: fifo_rd_en = ~fifo_empty & ((buf_cnt + inflight < 2) | pop).
  - Guarantees buffer occupancy never exceeds 2.
  - fifo_empty is sampled combinationally each cycle; no read is ever issued while fifo_empty=1.
- Capture: when inflight=1, fifo_data is written into the buffer at the next edge.
  - Written to slot 0 if slot 0 is empty after the pop, else slot 1.
  - Simultaneous capture and pop: slot 1 shifts to slot 0 and the new word goes to the freed position. Order is strictly FIFO order.
- buf_cnt next value = buf_cnt + inflight - pop.
- m_valid = (buf_cnt != 0); m_data = slot 0.
  - m_data holds stable while m_valid=1 and m_ready=0.
  - Slot contents are don't-care when not counted; m_data keeps its last value.
- Stream rule: once m_valid rises it stays high until a pop occurs. m_valid never depends combinationally on m_ready.
- Latency: with an idle, empty buffer, the cycle N in which fifo_empty falls has fifo_rd_en=1, and m_valid rises after edge N+2. First word reaches the stream 2 cycles after the read.
- Throughput:
  - With m_ready held at 1 and the FIFO non-empty, one beat per cycle in steady state (buf_cnt=1, inflight=1).
  - With m_ready held at 0, exactly 2 words are pulled from the FIFO and reading stops.
- beat_cnt increments by 1 on each pop and wraps from 2^CNT_WIDTH-1 to 0.
- Reset mid-operation: buffered and in-flight words are discarded. sync_fifo shares rst_n, so no data is owed after reset.

Test Plan:
- Fill-and-drain: after reset, write 8 words 0x11..0x88 into sync_fifo, m_ready=1 → stream delivers 0x11..0x88 in order on 8 consecutive cycles. First m_valid comes 2 cycles after the first fifo_rd_en. beat_cnt=8; fifo_rd_en never high while fifo_empty=1.
- Backpressure: FIFO holds 5 words, m_ready=0 → exactly 2 fifo_rd_en pulses, buf_cnt=2, m_data=first word held stable, FIFO fifo_cnt=3. Release m_ready=1 → remaining words arrive at 1 per cycle, order intact.
- Toggling ready: m_ready alternates 1/0 while 20 random words are written → all 20 received in order, no duplicates, buf_cnt never >2, beat_cnt=20.
- Simultaneous FIFO write and read: sync_fifo written every cycle for 40 cycles with random data, m_ready=1 → output sequence equals the input sequence delayed. Steady-state buf_cnt=1, sync_fifo fifo_cnt stays ≤1.
- Reset mid-stream: assert rst_n=0 while buf_cnt=2 and inflight=1 → m_valid=0, buf_cnt=0, beat_cnt=0 immediately (asynchronous). After release with the FIFO empty, fifo_rd_en stays 0 and m_valid stays 0.
- Counter wrap: with CNT_WIDTH=4, stream 17 words → beat_cnt reads 15 then 0 then 1.
